// File: rtl/basket_controller.sv
// ---------------------------------------------------------------------------
// basket_controller
//
// Purpose
//    Shopping-basket store of up to DEPTH (product ID, quantity) slots kept
//    contiguous in insertion order. It supports add (with optional merge of
//    duplicate IDs), remove-by-index with shift-down compaction, clear, and
//    a registered display readout port.
//
// Configuration
//    BASKET_MERGE_EN : when defined, an add first scans the occupied slots
//                      for a matching ID and merges into it (saturating at
//                      15). When undefined, every valid add goes straight
//                      to INSERT, so duplicate IDs occupy separate slots.
//
// Ports
//    CLOCK_50         in   1  system clock, rising edge
//    RESET            in   1  synchronous active-high reset
//    Enable           in   1  single-cycle add request
//    ProductID        in   4  product to add
//    ProductQuantity  in   4  quantity to add (1..4 legal)
//    Cancel           in   1  single-cycle slot-removal request
//    CancelIndex      in   4  slot to remove
//    Clear            in   1  empty the basket (works in any state)
//    ReadIndex        in   4  readout slot address
//    ReadProductID    out  4  registered ID of slot ReadIndex (0 if empty)
//    ReadQuantity     out  4  registered quantity of slot ReadIndex
//    BasketProductNum out  4  number of occupied slots
//    TotalItems       out  7  sum of all slot quantities
//    Full             out  1  all DEPTH slots occupied
//    Busy             out  1  an operation is in progress
//    Error            out  1  single-cycle pulse on a rejected request
// ---------------------------------------------------------------------------
module basket_controller #(
   parameter int DEPTH = 8
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       Enable,
   input  logic [3:0] ProductID,
   input  logic [3:0] ProductQuantity,
   input  logic       Cancel,
   input  logic [3:0] CancelIndex,
   input  logic       Clear,
   input  logic [3:0] ReadIndex,
   output logic [3:0] ReadProductID,
   output logic [3:0] ReadQuantity,
   output logic [3:0] BasketProductNum,
   output logic [6:0] TotalItems,
   output logic       Full,
   output logic       Busy,
   output logic       Error
);

   typedef enum logic [1:0] {IDLE, SEARCH, INSERT, SHIFT} stateT;

   localparam logic [3:0] DEPTH_L = 4'(DEPTH);

   stateT       stateQ, stateD;
   logic [3:0]  idQ  [DEPTH];
   logic [3:0]  idD  [DEPTH];
   logic [3:0]  qtyQ [DEPTH];
   logic [3:0]  qtyD [DEPTH];
   logic [3:0]  countQ, countD;
   logic [7:0]  totalQ, totalD;
   logic [3:0]  idxQ, idxD;
   logic [3:0]  addIdQ, addIdD;
   logic [3:0]  addQtyQ, addQtyD;
   logic [3:0]  remQtyQ, remQtyD;
   logic        firstQ, firstD;
   logic        errorQ, errorD;
   logic [3:0]  readIdQ, readQtyQ;

   logic [3:0]  nextId, nextQty, cancelQty, readId, readQty;
   logic        full, qtyValid;

`ifdef BASKET_MERGE_EN
   logic [3:0]  curId, curQty;
   logic [4:0]  mergeSum;
   logic [3:0]  mergeQty;

   assign mergeSum = {1'b0, curQty} + {1'b0, addQtyQ};
   assign mergeQty = (mergeSum > 5'd15) ? 4'd15 : mergeSum[3:0];
`endif

   assign full     = (countQ == DEPTH_L);
   assign qtyValid = (ProductQuantity != 4'd0) && (ProductQuantity <= 4'd4);

   // Slot read multiplexers. Indexing is done by equality compare over the
   // slot loop so that 4-bit indices never select past the array; the
   // readout mux also forces 0 for unoccupied or out-of-range slots.
   always_comb begin
`ifdef BASKET_MERGE_EN
      curId     = '0;
      curQty    = '0;
`endif
      nextId    = '0;
      nextQty   = '0;
      cancelQty = '0;
      readId    = '0;
      readQty   = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef BASKET_MERGE_EN
         if (4'(i) == idxQ) begin
            curId  = idQ[i];
            curQty = qtyQ[i];
         end
`endif
         if (4'(i) == idxQ + 4'd1) begin
            nextId  = idQ[i];
            nextQty = qtyQ[i];
         end
         if (4'(i) == CancelIndex) begin
            cancelQty = qtyQ[i];
         end
         if ((4'(i) == ReadIndex) && (4'(i) < countQ)) begin
            readId  = idQ[i];
            readQty = qtyQ[i];
         end
      end
   end

   // Next-state and datapath logic. Clear overrides whatever is in flight.
   // In IDLE, Cancel beats Enable. Requests arriving while busy are dropped
   // and flagged. A Full error is raised on the transition into INSERT so
   // that the pulse is visible during the INSERT cycle itself. The removed
   // quantity is taken off the total on the first SHIFT cycle, which is
   // when slot contents first change.
   always_comb begin
      stateD  = stateQ;
      countD  = countQ;
      totalD  = totalQ;
      idxD    = idxQ;
      addIdD  = addIdQ;
      addQtyD = addQtyQ;
      remQtyD = remQtyQ;
      firstD  = firstQ;
      errorD  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idD[i]  = idQ[i];
         qtyD[i] = qtyQ[i];
      end

      if (Clear) begin
         stateD = IDLE;
         countD = '0;
         totalD = '0;
         for (int i = 0; i < DEPTH; i++) begin
            idD[i]  = '0;
            qtyD[i] = '0;
         end
      end else begin
         case (stateQ)
            IDLE: begin
               if (Cancel) begin
                  if (CancelIndex < countQ) begin
                     stateD  = SHIFT;
                     idxD    = CancelIndex;
                     remQtyD = cancelQty;
                     firstD  = 1'b1;
                  end else begin
                     errorD = 1'b1;
                  end
               end else if (Enable) begin
                  if (qtyValid) begin
                     addIdD  = ProductID;
                     addQtyD = ProductQuantity;
`ifdef BASKET_MERGE_EN
                     if (countQ == 4'd0) begin
                        stateD = INSERT;
                     end else begin
                        stateD = SEARCH;
                        idxD   = '0;
                     end
`else
                     stateD = INSERT;
                     errorD = full;
`endif
                  end else begin
                     errorD = 1'b1;
                  end
               end
            end

`ifdef BASKET_MERGE_EN
            SEARCH: begin
               errorD = Enable | Cancel;
               if (curId == addIdQ) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (4'(i) == idxQ) begin
                        qtyD[i] = mergeQty;
                     end
                  end
                  totalD = totalQ + {4'b0, mergeQty} - {4'b0, curQty};
                  stateD = IDLE;
               end else if (idxQ == countQ - 4'd1) begin
                  stateD = INSERT;
                  errorD = errorD | full;
               end else begin
                  idxD = idxQ + 4'd1;
               end
            end
`endif

            INSERT: begin
               errorD = Enable | Cancel;
               if (!full) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (4'(i) == countQ) begin
                        idD[i]  = addIdQ;
                        qtyD[i] = addQtyQ;
                     end
                  end
                  countD = countQ + 4'd1;
                  totalD = totalQ + {4'b0, addQtyQ};
               end
               stateD = IDLE;
            end

            SHIFT: begin
               errorD = Enable | Cancel;
               if (firstQ) begin
                  totalD = totalQ - {4'b0, remQtyQ};
               end
               firstD = 1'b0;
               if (idxQ < countQ - 4'd1) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (4'(i) == idxQ) begin
                        idD[i]  = nextId;
                        qtyD[i] = nextQty;
                     end
                  end
                  idxD = idxQ + 4'd1;
               end else begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (4'(i) == idxQ) begin
                        idD[i]  = '0;
                        qtyD[i] = '0;
                     end
                  end
                  countD = countQ - 4'd1;
                  stateD = IDLE;
               end
            end

            default: stateD = IDLE;
         endcase
      end
   end

   // State and storage registers with synchronous reset that wipes every
   // slot, so nothing written mid-operation survives a reset.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         stateQ   <= IDLE;
         countQ   <= '0;
         totalQ   <= '0;
         idxQ     <= '0;
         addIdQ   <= '0;
         addQtyQ  <= '0;
         remQtyQ  <= '0;
         firstQ   <= 1'b0;
         errorQ   <= 1'b0;
         readIdQ  <= '0;
         readQtyQ <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            idQ[i]  <= '0;
            qtyQ[i] <= '0;
         end
      end else begin
         stateQ   <= stateD;
         countQ   <= countD;
         totalQ   <= totalD;
         idxQ     <= idxD;
         addIdQ   <= addIdD;
         addQtyQ  <= addQtyD;
         remQtyQ  <= remQtyD;
         firstQ   <= firstD;
         errorQ   <= errorD;
         readIdQ  <= readId;
         readQtyQ <= readQty;
         for (int i = 0; i < DEPTH; i++) begin
            idQ[i]  <= idD[i];
            qtyQ[i] <= qtyD[i];
         end
      end
   end

   // The internal total is 8 bits wide; the 7-bit output clamps rather than
   // wrapping for large DEPTH.
   assign ReadProductID    = readIdQ;
   assign ReadQuantity     = readQtyQ;
   assign BasketProductNum = countQ;
   assign TotalItems       = (totalQ > 8'd127) ? 7'd127 : totalQ[6:0];
   assign Full             = full;
   assign Busy             = (stateQ != IDLE);
   assign Error            = errorQ;

endmodule

// File: tb/tb_basket_controller.sv
// ---------------------------------------------------------------------------
// tb_basket_controller
//
// Self-checking bench for basket_controller (DEPTH = 8). A constant vector
// table covers the basic add/cancel/clear/readout behaviour, hand-written
// sequences cover requests while busy, Clear and RESET mid-operation, and a
// randomized phase is compared against a queue-based basket model.
// Honours BASKET_MERGE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_basket_controller;

   localparam int DEPTH = 8;

   logic       CLOCK_50 = 1'b0;
   logic       RESET = 1'b1;
   logic       Enable = 1'b0;
   logic [3:0] ProductID = '0;
   logic [3:0] ProductQuantity = '0;
   logic       Cancel = 1'b0;
   logic [3:0] CancelIndex = '0;
   logic       Clear = 1'b0;
   logic [3:0] ReadIndex = '0;
   logic [3:0] ReadProductID, ReadQuantity, BasketProductNum;
   logic [6:0] TotalItems;
   logic       Full, Busy, Error;

   int checks = 0;
   int errors = 0;

   typedef enum int {OP_ADD, OP_CANCEL, OP_CLEAR, OP_READ} opT;
   typedef struct {
      opT         op;
      logic [3:0] a;
      logic [3:0] b;
      int         expCount;
      int         expTotal;
      bit         expErr;
      int         expId;
      int         expQty;
   } vecT;

   vecT vecs[$];
   int  modelId[$];
   int  modelQty[$];

   basket_controller #(.DEPTH(DEPTH)) dut (
      .CLOCK_50        (CLOCK_50),
      .RESET           (RESET),
      .Enable          (Enable),
      .ProductID       (ProductID),
      .ProductQuantity (ProductQuantity),
      .Cancel          (Cancel),
      .CancelIndex     (CancelIndex),
      .Clear           (Clear),
      .ReadIndex       (ReadIndex),
      .ReadProductID   (ReadProductID),
      .ReadQuantity    (ReadQuantity),
      .BasketProductNum(BasketProductNum),
      .TotalItems      (TotalItems),
      .Full            (Full),
      .Busy            (Busy),
      .Error           (Error)
   );

   // 50 MHz-style free-running clock
   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic vecT mk(opT op, int a, int b, int cnt, int tot, bit err, int id, int q);
      vecT v;
      v.op = op; v.a = 4'(a); v.b = 4'(b);
      v.expCount = cnt; v.expTotal = tot; v.expErr = err;
      v.expId = id; v.expQty = q;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one request for a single cycle, then follow Busy until idle,
   // collecting any Error pulse and the number of busy cycles.
   task automatic applyStimulus(input opT op, input logic [3:0] a, input logic [3:0] b,
                                output bit errSeen, output int busyCycles);
      @(negedge CLOCK_50);
      case (op)
         OP_ADD:    begin Enable = 1'b1; ProductID = a; ProductQuantity = b; end
         OP_CANCEL: begin Cancel = 1'b1; CancelIndex = a; end
         OP_CLEAR:  Clear = 1'b1;
         default:   ;
      endcase
      @(negedge CLOCK_50);
      Enable = 1'b0; Cancel = 1'b0; Clear = 1'b0;
      errSeen = Error;
      busyCycles = 0;
      while (Busy && busyCycles < 64) begin
         busyCycles++;
         @(negedge CLOCK_50);
         if (Error) errSeen = 1'b1;
      end
      if (Busy) checkOutput("idleTimeout", 1, 0);
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while (Busy && n < 64) begin
         n++;
         @(negedge CLOCK_50);
      end
      if (Busy) checkOutput(name, 1, 0);
   endtask

   task automatic readSlot(input logic [3:0] idx, output int id, output int q);
      @(negedge CLOCK_50);
      ReadIndex = idx;
      @(negedge CLOCK_50);
      id = ReadProductID;
      q  = ReadQuantity;
   endtask

   task automatic checkState(input string name, input int cnt, input int tot);
      checkOutput({name, " count"}, BasketProductNum, cnt);
      checkOutput({name, " total"}, TotalItems, tot);
      checkOutput({name, " full"}, Full, (cnt == DEPTH) ? 1 : 0);
   endtask

   // Empty the basket then load IDs 1..4 with quantity equal to the ID.
   task automatic buildBasket();
      bit e; int bc;
      applyStimulus(OP_CLEAR, 4'd0, 4'd0, e, bc);
      for (int i = 1; i <= 4; i++) applyStimulus(OP_ADD, 4'(i), 4'(i), e, bc);
   endtask

   function automatic int modelTotal();
      int s;
      s = 0;
      foreach (modelQty[j]) s += modelQty[j];
      return (s > 127) ? 127 : s;
   endfunction

   task automatic checkModelSlots(input string name);
      int id, q;
      for (int i = 0; i < DEPTH; i++) begin
         readSlot(4'(i), id, q);
         checkOutput($sformatf("%s slot%0d id", name, i), id, (i < modelId.size()) ? modelId[i] : 0);
         checkOutput($sformatf("%s slot%0d qty", name, i), q, (i < modelQty.size()) ? modelQty[i] : 0);
      end
   endtask

   initial begin
      bit   e;
      int   bc, id, q, pre, expBusy, found, r, rid, rq, ridx, s;
      bit   expE;
      vecT  v;

      // Basic table: distinct IDs, so expectations hold with or without merge
      vecs.push_back(mk(OP_ADD,    3, 2, 1,  2, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    5, 1, 2,  3, 0, 0, 0));
      vecs.push_back(mk(OP_READ,   0, 0, 2,  3, 0, 3, 2));
      vecs.push_back(mk(OP_READ,   1, 0, 2,  3, 0, 5, 1));
      vecs.push_back(mk(OP_READ,   2, 0, 2,  3, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    7, 0, 2,  3, 1, 0, 0));
      vecs.push_back(mk(OP_ADD,    7, 5, 2,  3, 1, 0, 0));
      vecs.push_back(mk(OP_CANCEL, 2, 0, 2,  3, 1, 0, 0));
      vecs.push_back(mk(OP_CANCEL, 0, 0, 1,  1, 0, 0, 0));
      vecs.push_back(mk(OP_READ,   0, 0, 1,  1, 0, 5, 1));
      vecs.push_back(mk(OP_CLEAR,  0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    1, 1, 1,  1, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    2, 2, 2,  3, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    3, 3, 3,  6, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    4, 4, 4, 10, 0, 0, 0));
      vecs.push_back(mk(OP_CANCEL, 1, 0, 3,  8, 0, 0, 0));
      vecs.push_back(mk(OP_READ,   0, 0, 3,  8, 0, 1, 1));
      vecs.push_back(mk(OP_READ,   1, 0, 3,  8, 0, 3, 3));
      vecs.push_back(mk(OP_READ,   2, 0, 3,  8, 0, 4, 4));
      vecs.push_back(mk(OP_CANCEL, 3, 0, 3,  8, 1, 0, 0));
      vecs.push_back(mk(OP_ADD,    5, 1, 4,  9, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    6, 1, 5, 10, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    7, 1, 6, 11, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    8, 1, 7, 12, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,    9, 1, 8, 13, 0, 0, 0));
      vecs.push_back(mk(OP_ADD,   10, 1, 8, 13, 1, 0, 0));
      vecs.push_back(mk(OP_READ,   7, 0, 8, 13, 0, 9, 1));
      vecs.push_back(mk(OP_READ,  15, 0, 8, 13, 0, 0, 0));

      // Reset state
      repeat (2) @(negedge CLOCK_50);
      checkOutput("rst busy", Busy, 0);
      checkOutput("rst error", Error, 0);
      checkOutput("rst readId", ReadProductID, 0);
      checkOutput("rst readQty", ReadQuantity, 0);
      checkState("rst", 0, 0);
      RESET = 1'b0;

      // Table-driven vectors
      pre = 0;
      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         if (v.op == OP_READ) begin
            readSlot(v.a, id, q);
            checkOutput($sformatf("vec%0d readId", k), id, v.expId);
            checkOutput($sformatf("vec%0d readQty", k), q, v.expQty);
         end else begin
            applyStimulus(v.op, v.a, v.b, e, bc);
            expBusy = 0;
            if (v.op == OP_ADD && v.b >= 1 && v.b <= 4) begin
`ifdef BASKET_MERGE_EN
               expBusy = pre + 1;
`else
               expBusy = 1;
`endif
            end else if (v.op == OP_CANCEL && int'(v.a) < pre) begin
               expBusy = pre - int'(v.a);
            end
            checkState($sformatf("vec%0d", k), v.expCount, v.expTotal);
            checkOutput($sformatf("vec%0d error", k), e, v.expErr);
            checkOutput($sformatf("vec%0d busyCycles", k), bc, expBusy);
         end
         pre = v.expCount;
      end

      // Enable while SHIFT is running: dropped with an Error pulse
      buildBasket();
      @(negedge CLOCK_50);
      Cancel = 1'b1; CancelIndex = 4'd0;
      @(negedge CLOCK_50);
      Cancel = 1'b0; Enable = 1'b1; ProductID = 4'd9; ProductQuantity = 4'd1;
      checkOutput("shift busy", Busy, 1);
      @(negedge CLOCK_50);
      Enable = 1'b0;
      checkOutput("shift enable error", Error, 1);
      waitIdle("shift idleTimeout");
      checkState("shift drop", 3, 9);
      for (int i = 0; i < 4; i++) begin
         readSlot(4'(i), id, q);
         checkOutput($sformatf("shift drop slot%0d id", i), id, (i < 3) ? i + 2 : 0);
      end

      // Clear during SHIFT aborts and empties next cycle
      buildBasket();
      @(negedge CLOCK_50);
      Cancel = 1'b1; CancelIndex = 4'd0;
      @(negedge CLOCK_50);
      Cancel = 1'b0; Clear = 1'b1;
      @(negedge CLOCK_50);
      Clear = 1'b0;
      checkState("clear in shift", 0, 0);
      checkOutput("clear in shift busy", Busy, 0);

      // Clear and Enable together in IDLE: Clear wins, no Error
      buildBasket();
      @(negedge CLOCK_50);
      Clear = 1'b1; Enable = 1'b1; ProductID = 4'd5; ProductQuantity = 4'd1;
      @(negedge CLOCK_50);
      Clear = 1'b0; Enable = 1'b0;
      checkOutput("clear+enable error", Error, 0);
      checkOutput("clear+enable busy", Busy, 0);
      checkState("clear+enable", 0, 0);

`ifdef BASKET_MERGE_EN
      // Merge into slot 0 until it saturates at 15
      applyStimulus(OP_ADD, 4'd3, 4'd2, e, bc);
      applyStimulus(OP_ADD, 4'd5, 4'd1, e, bc);
      applyStimulus(OP_ADD, 4'd3, 4'd4, e, bc);
      checkOutput("merge busyCycles", bc, 1);
      checkState("merge", 2, 7);
      readSlot(4'd0, id, q);
      checkOutput("merge slot0 qty", q, 6);
      applyStimulus(OP_ADD, 4'd3, 4'd4, e, bc);
      applyStimulus(OP_ADD, 4'd3, 4'd4, e, bc);
      applyStimulus(OP_ADD, 4'd3, 4'd4, e, bc);
      readSlot(4'd0, id, q);
      checkOutput("merge sat qty", q, 15);
      checkState("merge sat", 2, 16);

      // Clear during SEARCH
      @(negedge CLOCK_50);
      Enable = 1'b1; ProductID = 4'd9; ProductQuantity = 4'd1;
      @(negedge CLOCK_50);
      Enable = 1'b0; Clear = 1'b1;
      checkOutput("search busy", Busy, 1);
      @(negedge CLOCK_50);
      Clear = 1'b0;
      checkState("clear in search", 0, 0);
`else
      // Duplicate IDs occupy separate slots
      applyStimulus(OP_ADD, 4'd3, 4'd2, e, bc);
      applyStimulus(OP_ADD, 4'd3, 4'd2, e, bc);
      checkState("dup", 2, 4);
      readSlot(4'd1, id, q);
      checkOutput("dup slot1 id", id, 3);
      checkOutput("dup slot1 qty", q, 2);
`endif

      // RESET in the middle of SHIFT: everything back to zero
      buildBasket();
      @(negedge CLOCK_50);
      ReadIndex = 4'd0; Cancel = 1'b1; CancelIndex = 4'd0;
      @(negedge CLOCK_50);
      Cancel = 1'b0; RESET = 1'b1;
      @(negedge CLOCK_50);
      RESET = 1'b0;
      checkState("rst mid shift", 0, 0);
      checkOutput("rst mid shift busy", Busy, 0);
      checkOutput("rst mid shift error", Error, 0);
      checkOutput("rst mid shift readId", ReadProductID, 0);
      checkOutput("rst mid shift readQty", ReadQuantity, 0);
      applyStimulus(OP_ADD, 4'd7, 4'd1, e, bc);
      readSlot(4'd1, id, q);
      checkOutput("after rst slot1 id", id, 0);

      // Randomized operations against the queue model
      applyStimulus(OP_CLEAR, 4'd0, 4'd0, e, bc);
      modelId.delete();
      modelQty.delete();
      for (int n = 0; n < 250; n++) begin
         r    = $urandom_range(0, 99);
         rid  = $urandom_range(0, 11);
         rq   = $urandom_range(0, 5);
         ridx = $urandom_range(0, 9);
         pre  = modelId.size();
         expE = 1'b0;
         expBusy = 0;
         if (r < 55) begin
            applyStimulus(OP_ADD, 4'(rid), 4'(rq), e, bc);
            if (rq < 1 || rq > 4) begin
               expE = 1'b1;
            end else begin
               found = -1;
`ifdef BASKET_MERGE_EN
               foreach (modelId[j]) begin
                  if (found < 0 && modelId[j] == rid) found = j;
               end
`endif
               if (found >= 0) begin
                  s = modelQty[found] + rq;
                  modelQty[found] = (s > 15) ? 15 : s;
                  expBusy = found + 1;
               end else begin
`ifdef BASKET_MERGE_EN
                  expBusy = pre + 1;
`else
                  expBusy = 1;
`endif
                  if (pre == DEPTH) expE = 1'b1;
                  else begin
                     modelId.push_back(rid);
                     modelQty.push_back(rq);
                  end
               end
            end
         end else if (r < 88) begin
            applyStimulus(OP_CANCEL, 4'(ridx), 4'd0, e, bc);
            if (ridx >= pre) expE = 1'b1;
            else begin
               expBusy = pre - ridx;
               modelId.delete(ridx);
               modelQty.delete(ridx);
            end
         end else if (r < 92) begin
            applyStimulus(OP_CLEAR, 4'd0, 4'd0, e, bc);
            modelId.delete();
            modelQty.delete();
         end else begin
            readSlot(4'(ridx), id, q);
            checkOutput($sformatf("rnd%0d readId", n), id, (ridx < pre) ? modelId[ridx] : 0);
            checkOutput($sformatf("rnd%0d readQty", n), q, (ridx < pre) ? modelQty[ridx] : 0);
            continue;
         end
         checkState($sformatf("rnd%0d", n), modelId.size(), modelTotal());
         checkOutput($sformatf("rnd%0d error", n), e, expE);
         checkOutput($sformatf("rnd%0d busyCycles", n), bc, expBusy);
         if (n % 25 == 24) checkModelSlots($sformatf("rnd%0d", n));
      end
      checkModelSlots("rnd end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
